// File: rtl/wb_bypass_pkg.sv
// wb_bypass_pkg: shared widths, entry type and age-width helper for the writeback bypass
package wb_bypass_pkg;
   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;
   typedef struct packed {
      logic              valid;
      logic [AW_DEF-1:0] idx;
      logic [DW_DEF-1:0] data;
   } wb_entry_t;
   function automatic int age_w();
      return 3;
   endfunction
endpackage

// File: rtl/wb_bypass_match.sv
// wb_bypass_match: priority-encodes one read port against all candidates (lowest age, then youngest lane)
module wb_bypass_match
   import wb_bypass_pkg::*;
#(
   parameter int ND    = 3,
   parameter int NLANE = 2,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic [ND*NLANE-1:0]    in_cand_v,
   input  logic [ND*NLANE*AW-1:0] in_cand_idx,
   input  logic [ND*NLANE*DW-1:0] in_cand_data,
   input  logic [AW-1:0]          in_rd_idx,
   output logic                   out_hit,
   output logic [DW-1:0]          out_data,
   output logic [2:0]             out_age
);
   // scan from lowest priority to highest so the last match wins
   always_comb begin
      out_hit  = 1'b0;
      out_data = '0;
      out_age  = '0;
      for (int a = ND - 1; a >= 0; a--)
         for (int k = 0; k < NLANE; k++)
            if (in_cand_v[a*NLANE+k] && in_cand_idx[(a*NLANE+k)*AW +: AW] == in_rd_idx && in_rd_idx != '0) begin
               out_hit  = 1'b1;
               out_data = in_cand_data[(a*NLANE+k)*DW +: DW];
               out_age  = 3'(a);
            end
   end
endmodule

// File: rtl/wb_bypass_buffer.sv
// wb_bypass_buffer: DEPTH-slot writeback history forwarding to NREAD register-file read ports
module wb_bypass_buffer
   import wb_bypass_pkg::*;
#(
   parameter int NLANE      = 2,
   parameter int NREAD      = 4,
   parameter int DEPTH      = 2,
   parameter int DW         = DW_DEF,
   parameter int AW         = AW_DEF,
   parameter int CUR_BYPASS = 1
) (
   input  logic                in_clk,
   input  logic                in_rst,
   input  logic [NLANE-1:0]    in_wb_we,
   input  logic [NLANE*AW-1:0] in_wb_idx,
   input  logic [NLANE*DW-1:0] in_wb_data,
   input  logic                in_clr,
   input  logic [NREAD*AW-1:0] in_rd_idx,
   output logic [NREAD-1:0]    out_hit,
   output logic [NREAD*DW-1:0] out_data,
   output logic [NREAD*3-1:0]  out_age
);
   localparam int NH = DEPTH * NLANE;
   logic [NLANE-1:0] cur_v;
   logic [NH-1:0]    hist_v;
   logic [NH*AW-1:0] hist_idx;
   logic [NH*DW-1:0] hist_data;
   always_comb begin
      cur_v = '0;
      for (int k = 0; k < NLANE; k++)
         cur_v[k] = in_wb_we[k] && in_wb_idx[k*AW +: AW] != '0;
   end
   // slot 1 sits just above the current writebacks, so a shift is a truncated concatenation
   always_ff @(posedge in_clk) begin
      if (in_rst || in_clr) begin
         hist_v    <= '0;
         hist_idx  <= '0;
         hist_data <= '0;
      end else begin
         hist_v    <= NH'({hist_v, cur_v});
         hist_idx  <= (NH*AW)'({hist_idx, in_wb_idx});
         hist_data <= (NH*DW)'({hist_data, in_wb_data});
      end
   end
   for (genvar p = 0; p < NREAD; p++) begin : g_port
      wb_bypass_match #(.ND(DEPTH + 1), .NLANE(NLANE), .AW(AW), .DW(DW)) u_match (
         .in_cand_v   ({hist_v, cur_v & {NLANE{CUR_BYPASS != 0}}}),
         .in_cand_idx ({hist_idx, in_wb_idx}),
         .in_cand_data({hist_data, in_wb_data}),
         .in_rd_idx   (in_rd_idx[p*AW +: AW]),
         .out_hit     (out_hit[p]),
         .out_data    (out_data[p*DW +: DW]),
         .out_age     (out_age[p*3 +: 3])
      );
   end
endmodule

// File: tb/tb_wb_bypass_buffer.sv
// tb_wb_bypass_buffer: directed plus random checks of two bypass configurations against a queue model
module tb_wb_bypass_buffer;
   localparam int NL = 2, NR = 4, D = 2, DW = 32, AW = 5;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, clr;
   logic [NL-1:0]    we;
   logic [NL*AW-1:0] wi;
   logic [NL*DW-1:0] wd;
   logic [NR*AW-1:0] ri;
   logic [NR-1:0]    hit0, hit1;
   logic [NR*DW-1:0] data0, data1;
   logic [NR*3-1:0]  age0, age1;
   int errors = 0, checks = 0;
   typedef struct packed {
      logic [NL-1:0]    we;
      logic [NL*AW-1:0] idx;
      logic [NL*DW-1:0] data;
   } rec_t;
   rec_t q[$];
   wb_bypass_buffer #(.NLANE(NL), .NREAD(NR), .DEPTH(D), .DW(DW), .AW(AW), .CUR_BYPASS(1)) dut0 (
      .in_clk(clk), .in_rst(rst), .in_wb_we(we), .in_wb_idx(wi), .in_wb_data(wd),
      .in_clr(clr), .in_rd_idx(ri), .out_hit(hit0), .out_data(data0), .out_age(age0));
   wb_bypass_buffer #(.NLANE(NL), .NREAD(NR), .DEPTH(D), .DW(DW), .AW(AW), .CUR_BYPASS(0)) dut1 (
      .in_clk(clk), .in_rst(rst), .in_wb_we(we), .in_wb_idx(wi), .in_wb_data(wd),
      .in_clr(clr), .in_rd_idx(ri), .out_hit(hit1), .out_data(data1), .out_age(age1));
   // newest write to r among the current cycle (optional) and the remembered cycles
   function automatic logic [35:0] ref_look(int cb, logic [AW-1:0] r);
      rec_t e;
      for (int a = 0; a <= q.size(); a++) begin
         if (a == 0 && cb == 0) continue;
         e = (a == 0) ? {we, wi, wd} : q[a-1];
         for (int k = NL - 1; k >= 0; k--)
            if (r != 0 && e.we[k] && e.idx[k*AW +: AW] == r)
               return {1'b1, 3'(a), e.data[k*DW +: DW]};
      end
      return '0;
   endfunction
   task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask
   task automatic check_ports();
      logic [35:0] e;
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
         e = ref_look(1, ri[p*AW +: AW]);
         chk($sformatf("cb1_p%0d_hit", p), 64'(hit0[p]), 64'(e[35]));
         chk($sformatf("cb1_p%0d_age", p), 64'(age0[p*3 +: 3]), 64'(e[34:32]));
         chk($sformatf("cb1_p%0d_data", p), 64'(data0[p*DW +: DW]), 64'(e[31:0]));
         e = ref_look(0, ri[p*AW +: AW]);
         chk($sformatf("cb0_p%0d_all", p), 64'({hit1[p], age1[p*3 +: 3], data1[p*DW +: DW]}), 64'(e));
      end
   endtask
   task automatic tick();
      @(posedge clk);
      if (rst || clr) q.delete();
      else begin
         q.push_front({we, wi, wd});
         if (q.size() > D) void'(q.pop_back());
      end
      #1;
   endtask
   task automatic wr(int k, logic [AW-1:0] r, logic [DW-1:0] d);
      we[k] = 1'b1;
      wi[k*AW +: AW] = r;
      wd[k*DW +: DW] = d;
   endtask
   initial begin
      rst = 1'b1; clr = 1'b0; we = '0; wi = '0; wd = '0;
      ri = {5'd6, 5'd5, 5'd4, 5'd3};
      tick(); tick();
      rst = 1'b0;
      check_ports();
      chk("reset_hit", 64'(hit0), 64'(0));
      chk("reset_data", 64'(data0[63:0]), 64'(0));
      tick();
      wr(0, 5'd5, 32'hDEADBEEF); ri[0 +: AW] = 5'd5;
      check_ports();
      chk("age0_fwd", 64'({hit0[0], age0[2:0], data0[31:0]}), 64'({1'b1, 3'd0, 32'hDEADBEEF}));
      chk("cb0_nohit", 64'(hit1[0]), 64'(0));
      tick(); we = '0;
      check_ports();
      chk("cb0_age1", 64'({hit1[0], age1[2:0], data1[31:0]}), 64'({1'b1, 3'd1, 32'hDEADBEEF}));
      tick();
      wr(0, 5'd7, 32'h11); ri[0 +: AW] = 5'd7;
      for (int t = 0; t < 4; t++) begin
         check_ports();
         chk($sformatf("expiry_t%0d", t), 64'({hit0[0], age0[2:0]}), (t < 3) ? 64'({1'b1, 3'(t)}) : 64'(0));
         tick(); we = '0;
      end
      wr(0, 5'd9, 32'hAA); wr(1, 5'd9, 32'hBB); ri[0 +: AW] = 5'd9;
      check_ports();
      chk("lane_pri_a0", 64'({age0[2:0], data0[31:0]}), 64'({3'd0, 32'hBB}));
      tick(); we = '0;
      check_ports();
      chk("lane_pri_a1", 64'({age0[2:0], data0[31:0]}), 64'({3'd1, 32'hBB}));
      tick();
      wr(0, 5'd2, 32'h1); tick();
      wr(0, 5'd2, 32'h2); ri[0 +: AW] = 5'd2;
      check_ports();
      chk("age_pri", 64'({age0[2:0], data0[31:0]}), 64'({3'd0, 32'h2}));
      tick(); we = '0;
      wr(0, 5'd0, 32'hFFFF); ri = '0;
      for (int t = 0; t < 3; t++) begin
         check_ports();
         chk($sformatf("r0_t%0d", t), 64'(hit0), 64'(0));
         tick(); we = '0;
      end
      wr(0, 5'd3, 32'h33); ri[0 +: AW] = 5'd3;
      tick(); we = '0; clr = 1'b1;
      check_ports();
      tick(); clr = 1'b0;
      check_ports();
      chk("clr_gone", 64'(hit0[0]), 64'(0));
      tick();
      clr = 1'b1; wr(0, 5'd4, 32'h44); ri[0 +: AW] = 5'd4;
      check_ports();
      chk("clr_wb_a0", 64'({hit0[0], data0[31:0]}), 64'({1'b1, 32'h44}));
      tick(); clr = 1'b0; we = '0;
      check_ports();
      chk("clr_wb_after", 64'(hit0[0]), 64'(0));
      tick();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom % 50) == 0;
         clr = ($urandom % 30) == 0;
         we = NL'($urandom);
         for (int k = 0; k < NL; k++) begin
            wi[k*AW +: AW] = AW'($urandom_range(0, 7));
            wd[k*DW +: DW] = $urandom;
         end
         for (int p = 0; p < NR; p++) ri[p*AW +: AW] = AW'($urandom_range(0, 7));
         check_ports();
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
